rst_seq: RTL
============

// Module: rst_seq
// PURPOSE
// - Consumes the raw active-high reset driven by the simulation reset generator and fans it out.
// - Reset assertion is asynchronous; deassertion is synchronised to clk.
// - Per-stage resets are released in order, each gated by a ready handshake from the stage.
// - Sits between the reset source and the DUT subsystems (PHY, controller, user logic, ...).
// PARAMETERS
// - NUM_STAGES  4    number of sequenced reset outputs (>=1)
// - SYNC_STAGES 2    deassertion synchroniser depth (>=2)
// - MIN_HOLD    8    cycles all outputs stay asserted after the synchronised release (>=0)
// - STAGE_GAP   4    cycles from stage_ready[i] sampled high to release of stage i+1 (>=1)
// - TIMEOUT     256  max cycles waiting on stage_ready (used only with RST_SEQ_TIMEOUT_EN)
// PORTS
// - clk          in   1                      clock
// - reset        in   1                      raw reset; asynchronous, active-high
// - stage_ready  in   NUM_STAGES             stage i reports out-of-reset/calibrated; clk domain
// - rst_out      out  NUM_STAGES             per-stage reset, active-high
// - stage_idx    out  max(1,$clog2(NUM_STAGES))  index of stage currently being released
// - seq_done     out  1                      all stages released and acknowledged
// - timeout_err  out  1                      sticky: some stage_ready timed out
// BEHAVIOUR
// - Reset is asynchronous, active-high, and can occur at any time, including mid-sequence.
//   - On reset: rst_out = all 1s, stage_idx = 0, seq_done = 0, timeout_err = 0.
//   - FSM returns to HOLD and all counters clear.
//   - All of this happens immediately, without waiting for a clk edge; a sub-cycle glitch triggers a full restart.
// - Synchroniser: SYNC_STAGES flops, asynchronously set by reset, shifting in 0.
//   - rst_sync falls on the SYNC_STAGES-th rising edge after reset falls.
// - FSM states:
//   - HOLD: counter runs only while rst_sync = 0. After MIN_HOLD counts, clear rst_out[0] and go to WAIT_RDY.
//   - WAIT_RDY: sample stage_ready[stage_idx] each edge.
//     - If high and stage_idx = NUM_STAGES-1: go to DONE.
//     - If high otherwise: stage_idx++ and go to GAP.
//   - GAP: count STAGE_GAP edges, then clear rst_out[stage_idx] and go to WAIT_RDY.
//   - DONE: seq_done = 1. Stay here until reset.
// - Release timing:
//   - rst_out[0] falls on edge SYNC_STAGES+MIN_HOLD after reset falls.
//   - If ready is sampled high at edge k, rst_out[i+1] falls at edge k+STAGE_GAP.
//   - A stage_ready already high is still sampled: there is a minimum 1 cycle in WAIT_RDY.
// - Release is monotonic: a released rst_out bit stays 0 until the next reset.
// - stage_ready is ignored in HOLD, GAP and DONE. A ready drop after release has no effect.
// - Only stage_ready[stage_idx] matters; other bits are don't-care.
// - Counters are wide enough for max(MIN_HOLD, STAGE_GAP, TIMEOUT) and never wrap; each clears on every state entry.
// - NUM_STAGES = 1: stage_idx is a constant 0, and GAP is never entered.
// - All outputs are registered; no combinational path from inputs to outputs.
// CONFIGURATION
// - RST_SEQ_TIMEOUT_EN defined:
//   - WAIT_RDY counts cycles.
//   - On the TIMEOUT-th cycle without ready, set timeout_err (sticky) and treat the stage as ready, with the same transition.
// - RST_SEQ_TIMEOUT_EN undefined:
//   - WAIT_RDY waits indefinitely.
//   - timeout_err is tied to 0 and TIMEOUT is unused.
// TESTING (defaults unless stated; edges counted from reset falling)
// - stage_ready = 4'b1111, reset high 5 cycles then low:
//   - rst_out[0..3] fall at edges 10/15/20/25.
//   - seq_done rises at edge 26.
//   - timeout_err = 0.
// - stage_ready[1] held 0 until edge 40:
//   - rst_out[2] stays 1 and stage_idx = 1 until then.
//   - rst_out[2] falls at edge 44.
// - reset re-pulsed at edge 17: rst_out = 4'b1111, stage_idx = 0 and seq_done = 0 immediately; the sequence restarts from the new fall.
// - 1 ns reset glitch after seq_done: all outputs reassert asynchronously, followed by a full re-sequence.
// - RST_SEQ_TIMEOUT_EN, stage_ready[2] = 0 forever:
//   - timeout_err rises 256 cycles after entry to WAIT_RDY for stage 2.
//   - rst_out[3] is released and seq_done is reached.
//   - Without the macro: hangs with stage_idx = 2 and timeout_err = 0.
// - NUM_STAGES=1, MIN_HOLD=0, ready = 1: rst_out[0] falls at edge 2 and seq_done rises at edge 3.

Source files
------------

// File: rtl/rst_seq.sv
// rst_seq: reset sequencer. Asserts all per-stage resets asynchronously, synchronises
// the release to clk, then frees each stage in order after its ready handshake.
// Optional feature macro: RST_SEQ_TIMEOUT_EN (bounded wait on stage_ready, sticky timeout_err).
module rst_seq #(
    parameter int unsigned NUM_STAGES  = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MIN_HOLD    = 8,
    parameter int unsigned STAGE_GAP   = 4,
    parameter int unsigned TIMEOUT     = 256,
    localparam int unsigned IDX_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_STAGES-1:0] stage_ready,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic [IDX_W-1:0]      stage_idx,
    output logic                  seq_done,
    output logic                  timeout_err
);

    localparam int unsigned MAX_A = (MIN_HOLD > STAGE_GAP) ? MIN_HOLD : STAGE_GAP;
    localparam int unsigned MAX_V = (MAX_A > TIMEOUT) ? MAX_A : TIMEOUT;
    localparam int unsigned CNT_W = $clog2(MAX_V + 1) + 1;

    typedef enum logic [1:0] {
        HOLD     = 2'd0,
        WAIT_RDY = 2'd1,
        GAP      = 2'd2,
        DONE     = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_rel_c;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_STAGES-1:0]  rst_out_q, rst_out_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   done_q, done_d;
    logic                   terr_q, terr_d;
    logic                   adv_c;

    // Deassertion synchroniser: set asynchronously, shifts in 0 toward rst_sync (MSB).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
        end
    end

    // rst_sync is low already or falls at this edge; the hold count starts with its fall.
    assign sync_rel_c = ~sync_q[SYNC_STAGES-1] | ~sync_q[SYNC_STAGES-2];

    // State, counter and registered outputs; reset restarts everything immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= HOLD;
            cnt_q     <= '0;
            rst_out_q <= '1;
            idx_q     <= '0;
            done_q    <= 1'b0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rst_out_q <= rst_out_d;
            idx_q     <= idx_d;
            done_q    <= done_d;
            terr_q    <= terr_d;
        end
    end

    // Next-state and output logic; rst_out bits only ever clear outside reset.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rst_out_d = rst_out_q;
        idx_d     = idx_q;
        done_d    = done_q;
        terr_d    = terr_q;
        adv_c     = 1'b0;
        unique case (state_q)
            HOLD: begin
                if (sync_rel_c) begin
                    if (cnt_q == CNT_W'(MIN_HOLD)) begin
                        rst_out_d[0] = 1'b0;
                        cnt_d        = '0;
                        state_d      = WAIT_RDY;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            WAIT_RDY: begin
                adv_c = stage_ready[idx_q];
`ifdef RST_SEQ_TIMEOUT_EN
                if (!stage_ready[idx_q]) begin
                    if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        adv_c  = 1'b1;
                        terr_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`endif
                if (adv_c) begin
                    cnt_d = '0;
                    if (idx_q == IDX_W'(NUM_STAGES - 1)) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (cnt_q == CNT_W'(STAGE_GAP - 1)) begin
                    rst_out_d[idx_q] = 1'b0;
                    cnt_d            = '0;
                    state_d          = WAIT_RDY;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = HOLD;
            end
        endcase
    end

    assign rst_out     = rst_out_q;
    assign stage_idx   = idx_q;
    assign seq_done    = done_q;
    assign timeout_err = terr_q;

endmodule
